// File: rtl/psum_requant_unit.sv
// rtl/psum_requant_unit.sv - channel accumulator with bias, rounding shift, relu and saturation
module psum_requant_unit #(
  parameter int IN_W   = 29,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 10,
  parameter int BIAS_W = 32,
  parameter int SH_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         cfg_num_ch,
  input  logic [SH_W-1:0]          cfg_shift,
  input  logic                     cfg_relu,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         ch_cnt
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (OUT_W - 1));
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         n_q;
  logic [SH_W-1:0]          shift_q;
  logic                     relu_q;
  logic signed [BIAS_W-1:0] bias_q;

  logic                     first;
  logic                     accept;
  logic                     is_last;
  logic [CNT_W-1:0]         n_eff;
  logic [SH_W-1:0]          shift_eff;
  logic                     relu_eff;
  logic signed [BIAS_W-1:0] bias_eff;
  logic [CNT_W:0]           cnt_inc;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  clipped;
  logic signed [OUT_W-1:0]  sat;

  assign first    = (ch_cnt == '0);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = !first;

  // Effective config: live inputs on the first beat of a pixel, latched copy afterwards
  always_comb begin
    n_eff     = n_q;
    shift_eff = shift_q;
    relu_eff  = relu_q;
    bias_eff  = bias_q;
    if (first) begin
      n_eff     = (cfg_num_ch == '0) ? CNT_W'(1) : cfg_num_ch;
      shift_eff = cfg_shift;
      relu_eff  = cfg_relu;
      bias_eff  = bias;
    end
  end

  // Final-beat arithmetic: sum, round-half-up shift, relu, then clamp to the output range
  always_comb begin
    cnt_inc  = {1'b0, ch_cnt} + 1'b1;
    is_last  = (cnt_inc == {1'b0, n_eff});
    in_ext   = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
    bias_ext = {{(ACC_W - BIAS_W){bias_eff[BIAS_W-1]}}, bias_eff};
    sum      = acc + in_ext + bias_ext;
    rnd      = '0;
    if (shift_eff != '0) begin
      rnd = {{(ACC_W - 1){1'b0}}, 1'b1} << (shift_eff - 1'b1);
    end
    shifted = (sum + rnd) >>> shift_eff;
    clipped = (relu_eff && shifted[ACC_W-1]) ? '0 : shifted;
    if (clipped > SAT_MAX) begin
      sat = OUT_MAX;
    end else if (clipped < SAT_MIN) begin
      sat = OUT_MIN;
    end else begin
      sat = clipped[OUT_W-1:0];
    end
  end

  // Accumulator, channel counter and per-pixel config latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      ch_cnt  <= '0;
      n_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      bias_q  <= '0;
    end else if (accept) begin
      if (first) begin
        n_q     <= n_eff;
        shift_q <= shift_eff;
        relu_q  <= relu_eff;
        bias_q  <= bias_eff;
      end
      if (is_last) begin
        acc    <= '0;
        ch_cnt <= '0;
      end else begin
        acc    <= acc + in_ext;
        ch_cnt <= cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Output register: load on the last beat, hold under stall, clear once drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && is_last) begin
      out_valid <= 1'b1;
      out_data  <= sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_requant_unit.sv
// tb/tb_psum_requant_unit.sv - scoreboard bench for psum_requant_unit
module tb_psum_requant_unit;

  logic               clk;
  logic               rst;
  logic [9:0]         cfg_num_ch;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic signed [31:0] bias;
  logic               in_valid;
  logic signed [28:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ready;
  logic               busy;
  logic [9:0]         ch_cnt;

  int checks;
  int failures;
  int sb_q[$];

  psum_requant_unit dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_num_ch (cfg_num_ch),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .ch_cnt     (ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d[28:0];
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("beat_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", out_data, 64'sd99999);
      end else begin
        chk("sb_data", out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_num_ch = '0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    bias = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch_cnt", ch_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;

    // N=3 basic accumulation with bias
    cfg_num_ch = 10'd3; cfg_shift = 5'd0; cfg_relu = 1'b0; bias = 32'sd10;
    beat(100);
    chk("t1_cnt1", ch_cnt, 1);
    chk("t1_busy1", busy, 1);
    chk("t1_ov1", out_valid, 0);
    beat(-50);
    chk("t1_cnt2", ch_cnt, 2);
    chk("t1_busy2", busy, 1);
    sb_q.push_back(67);
    beat(7);
    chk("t1_cnt_done", ch_cnt, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_ov_latency", out_valid, 1);

    // N=1 rounding, back-to-back results
    cfg_num_ch = 10'd1; cfg_shift = 5'd4; bias = 32'sd0;
    sb_q.push_back(2);  beat(24);
    sb_q.push_back(1);  beat(23);
    chk("t2_ov_cont1", out_valid, 1);
    sb_q.push_back(-1); beat(-24);
    chk("t2_ov_cont2", out_valid, 1);
    @(posedge clk);
    #1 chk("t2_ov_drop", out_valid, 0);
    cfg_shift = 5'd1; bias = -32'sd3;
    sb_q.push_back(-1); beat(0);

    // relu and saturation, N=2
    cfg_num_ch = 10'd2; cfg_shift = 5'd0; cfg_relu = 1'b1; bias = 32'sd0;
    beat(-500); sb_q.push_back(0); beat(100);
    cfg_relu = 1'b0;
    beat(-500); sb_q.push_back(-400); beat(100);
    beat(40000); sb_q.push_back(32767); beat(0);
    beat(-40000); sb_q.push_back(-32768); beat(0);
    @(posedge clk);
    #1;

    // back-pressure
    cfg_num_ch = 10'd1; out_ready = 1'b0;
    sb_q.push_back(111); beat(111);
    in_valid = 1'b1; in_data = 29'sd222;
    sb_q.push_back(222);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 111);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_second_ov", out_valid, 1);
    chk("bp_second_data", out_data, 222);
    @(posedge clk);
    #1 chk("bp_no_dup", out_valid, 0);

    // config latched for the whole pixel
    cfg_num_ch = 10'd4; bias = 32'sd5;
    beat(1);
    cfg_num_ch = 10'd2; bias = 32'sd1000;
    beat(2);
    beat(3);
    chk("cl_cnt3", ch_cnt, 3);
    sb_q.push_back(15); beat(4);
    chk("cl_cnt_done", ch_cnt, 0);
    cfg_num_ch = 10'd0; bias = 32'sd0;
    sb_q.push_back(77); beat(77);
    chk("n0_cnt", ch_cnt, 0);
    chk("n0_ov", out_valid, 1);
    sb_q.push_back(9); beat(9);
    @(posedge clk);
    #1;

    // reset with pending output (result intentionally not expected)
    out_ready = 1'b0; cfg_num_ch = 10'd1;
    beat(555);
    chk("rs_pending", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_ov_clear", out_valid, 0);
    chk("rs_data_clear", out_data, 0);
    chk("rs_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;

    // reset mid-pixel, then a clean pixel
    cfg_num_ch = 10'd4; bias = 32'sd0;
    beat(1000);
    beat(2000);
    chk("rs_mid_cnt", ch_cnt, 2);
    #2 rst = 1'b0;
    #1;
    chk("rs_mid_cnt_clear", ch_cnt, 0);
    chk("rs_mid_busy_clear", busy, 0);
    chk("rs_mid_ov", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cfg_num_ch = 10'd4; bias = 32'sd3;
    beat(10);
    beat(20);
    beat(30);
    sb_q.push_back(103); beat(40);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
